// File: rtl/mul8s_err_monitor.sv
// mul8s_err_monitor: windowed MAE/WCE/EP statistics for an 8x8 signed approximate multiplier
module mul8s_err_monitor #(
  parameter int WIN_LOG2 = 16,
  parameter int ACC_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_a,
  input  logic [7:0]          in_b,
  input  logic [15:0]         in_o,
  output logic                busy,
  output logic                done,
  output logic [ACC_W-1:0]    sum_abs_err,
  output logic [16:0]         max_abs_err,
  output logic [WIN_LOG2:0]   err_count,
  output logic [WIN_LOG2:0]   smp_count
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [WIN_LOG2:0] LAST = (WIN_LOG2+1)'((1 << WIN_LOG2) - 1);
  logic [1:0] state, state_nx;
  logic drain_cnt, vld1, accept, go, last;
  logic signed [15:0] exact;
  logic [16:0] diff_nx, diff, abs_err;
  logic [ACC_W:0] sum_wide;
  assign accept   = in_valid & in_ready;
  assign go       = start & (state == IDLE | state == DONE);
  assign last     = accept & (smp_count == LAST);
  assign busy     = (state == RUN) | (state == DRAIN);
  assign exact    = $signed(in_a) * $signed(in_b);
  assign diff_nx  = {in_o[15], in_o} - {exact[15], exact};
  assign abs_err  = diff[16] ? 17'(-diff) : diff;
  assign sum_wide = {1'b0, sum_abs_err} + (ACC_W+1)'(abs_err);
  // Window sequencing: start opens a window, the last accept drains two cycles, then results hold
  always_comb begin
    state_nx = go ? RUN
             : (state == RUN && last) ? DRAIN
             : (state == DRAIN && drain_cnt) ? DONE
             : state;
  end
  // State, registered handshake, done pulse and stage-1 error register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= 1'b0;
      vld1      <= 1'b0;
      diff      <= '0;
    end else begin
      state     <= state_nx;
      in_ready  <= state_nx == RUN;
      done      <= state == DRAIN && state_nx == DONE;
      drain_cnt <= state == DRAIN && !drain_cnt;
      vld1      <= accept;
      if (accept) diff <= diff_nx;
    end
  end
  // Statistics: sample count at accept, error stats one stage later; start clears them all
  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      sum_abs_err <= '0;
      max_abs_err <= '0;
      err_count   <= '0;
      smp_count   <= '0;
    end else begin
      if (accept) smp_count <= smp_count + 1'b1;
      if (vld1) begin
        sum_abs_err <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
        if (abs_err > max_abs_err) max_abs_err <= abs_err;
        if (abs_err != 17'd0) err_count <= err_count + 1'b1;
      end
    end
  end
endmodule
